dual_port_ram_pipe: RTL

Parametrised simple dual-port RAM (one write port, one read port) for the Winograd tile and weight buffers. It generalises the fixed 16x960 RAM wrapper in four ways: configurable width and depth, a read-valid pipeline with an optional output register, defined same-address collision behaviour, and a hardware clear sequencer. It sits between the input-transform / weight-load stages and the element-wise multiply array.

---
 rtl/winograd_pkg.sv | 13 +
 rtl/sdp_ram_core.sv | 31 +++
 rtl/dual_port_ram_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd tile and weight buffers.
package winograd_pkg;

  // Clear sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Default word width shared with the tile buffers
  localparam int unsigned DATA_W_DEFAULT = 16;

endpackage

// File: rtl/sdp_ram_core.sv
// Behavioural simple dual-port storage: one write port, one registered read
// port, no reset. Kept separate so a foundry macro can be dropped in.
module sdp_ram_core
  import winograd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 960,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; same-address access returns the pre-write word
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dual_port_ram_pipe.sv
// Parametrised simple dual-port RAM with read-valid pipeline, optional output
// register, same-address write bypass, range checking and a zero-fill
// clear sequencer.
module dual_port_ram_pipe
  import winograd_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned DEPTH        = 960,
  parameter int unsigned ADDR_W       = 10,
  parameter bit          OUT_REG      = 1'b1,
  parameter bit          WRITE_BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_in_addr,
  input  logic [DATA_W-1:0] io_dataIn,
  input  logic              io_input_valid,
  input  logic [ADDR_W-1:0] io_output_addr,
  input  logic              io_output_valid,
  input  logic              io_clear,
  output logic [DATA_W-1:0] io_dataOut,
  output logic              io_dataOut_valid,
  output logic              io_busy,
  output logic              io_addr_error
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;

  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_take, rd_ok, collide, err_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, core_rdata;

  logic              v1, zero1, byp1, err;
  logic [DATA_W-1:0] byp_data1, d1;

  // Port qualification, range checks and write-port arbitration
  always_comb begin
    wr_in_range = {1'b0, io_in_addr} < DEPTH_EXT;
    rd_in_range = {1'b0, io_output_addr} < DEPTH_EXT;
    wr_ok       = io_input_valid && !busy && wr_in_range;
    rd_take     = io_output_valid && !busy;
    rd_ok       = rd_take && rd_in_range;
    collide     = WRITE_BYPASS && rd_ok && wr_ok && (io_in_addr == io_output_addr);
    err_next    = !busy && ((io_input_valid && !wr_in_range) ||
                            (io_output_valid && !rd_in_range));
    mem_we      = busy ? 1'b1 : wr_ok;
    mem_waddr   = busy ? clr_addr : io_in_addr;
    mem_wdata   = busy ? '0 : io_dataIn;
  end

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clock),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (rd_ok),
    .rd_addr (io_output_addr),
    .rd_data (core_rdata)
  );

  // Clear sequencer: zeroes one word per cycle, ignores io_clear while running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_clear) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // First read stage: valid, error pulse and data-select flags.
  // Select flags only move on an accepted read so that d1 holds between
  // reads even though it is a mux of the core output (core holds too).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      zero1     <= 1'b1;
      byp1      <= 1'b0;
      byp_data1 <= '0;
      err       <= 1'b0;
    end else begin
      v1  <= rd_take;
      err <= err_next;
      if (rd_take) begin
        zero1     <= !rd_in_range;
        byp1      <= collide;
        byp_data1 <= io_dataIn;
      end
    end
  end

  // Stage-1 read data: zero for out-of-range, bypass on collision
  always_comb begin
    d1 = core_rdata;
    if (zero1)     d1 = '0;
    else if (byp1) d1 = byp_data1;
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic              v2;
      logic [DATA_W-1:0] d2;

      // Optional output register; data only loads on a valid beat
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign io_dataOut       = d2;
      assign io_dataOut_valid = v2;
    end else begin : g_no_out_reg
      assign io_dataOut       = d1;
      assign io_dataOut_valid = v1;
    end
  endgenerate

  assign io_busy       = busy;
  assign io_addr_error = err;

endmodule
